spike_row_scheduler: RTL and testbench

Per-row spike scheduler between the external stimulus path, the neuron spike outputs and the synapse-row spike inputs of `nn`. It buffers recurrent neuron spikes in per-column pending flags, arbitrates each synapse row between external and recurrent spikes with a fair toggle, and delivers at most one registered spike per row per cycle. It also counts recurrent spikes lost to pending-flag collisions.

---
 rtl/spike_row_scheduler_if.sv | 31 +++
 rtl/spike_row_scheduler.sv | 166 ++++++++++++++++
 tb/tb_spike_row_scheduler.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_row_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : spike_row_scheduler_if
// Description : Per-row external spike handshake and registered spike output
//               bus of the spike row scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface spike_row_scheduler_if #(
    parameter int NUM_SYNAPSE_ROWS = 2,
    parameter int ADDR_WIDTH       = 6
);
    logic [NUM_SYNAPSE_ROWS-1:0]                 ext_valid;
    logic [NUM_SYNAPSE_ROWS-1:0][ADDR_WIDTH-1:0] ext_addr;
    logic [NUM_SYNAPSE_ROWS-1:0]                 ext_ready;
    logic [NUM_SYNAPSE_ROWS-1:0]                 out_valid;
    logic [NUM_SYNAPSE_ROWS-1:0][ADDR_WIDTH-1:0] out_addr;
    logic [NUM_SYNAPSE_ROWS-1:0]                 out_rec;

    // Stimulus source / row consumer side.
    modport master (
        output ext_valid, ext_addr,
        input  ext_ready, out_valid, out_addr, out_rec
    );

    // Scheduler side.
    modport slave (
        input  ext_valid, ext_addr,
        output ext_ready, out_valid, out_addr, out_rec
    );
endinterface
`default_nettype wire

// File: rtl/spike_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : spike_row_scheduler
// Description : Buffers recurrent neuron spikes in per-column pending flags,
//               arbitrates each synapse row between external and recurrent
//               spikes with a fair toggle, delivers one registered spike per
//               row per cycle and counts recurrent spikes lost to collisions.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_row_scheduler #(
    parameter int NUM_SYNAPSE_ROWS = 2,
    parameter int NUM_COLS         = 2,
    parameter int ADDR_WIDTH       = 6,
    parameter int REC_ADDR_BASE    = 32,
    parameter int DROP_CNT_WIDTH   = 8
) (
    input  wire                       clk,
    input  wire                       reset_n,
    spike_row_scheduler_if.slave      bus,
    input  wire  [NUM_COLS-1:0]       nrn_spike,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
    input  wire                       drop_clr
);
    localparam int R      = NUM_SYNAPSE_ROWS;
    // Most columns any one row owns; rows may differ by one column.
    localparam int K_MAX  = (NUM_COLS + R - 1) / R;
    localparam int RR_W   = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int CNT_W  = $clog2(NUM_COLS + 1);
    localparam int SUM_W  = DROP_CNT_WIDTH + CNT_W;

    // Registered state
    logic [NUM_COLS-1:0]             r_pend;
    logic [R-1:0][RR_W-1:0]          r_rr;
    logic [R-1:0]                    r_prio;
    logic [R-1:0]                    r_out_valid;
    logic [R-1:0][ADDR_WIDTH-1:0]    r_out_addr;
    logic [R-1:0]                    r_out_rec;
    logic [DROP_CNT_WIDTH-1:0]       r_drop_cnt;

    // Per-row arbitration results
    logic [R-1:0]                    w_rec_avail;
    logic [R-1:0]                    w_grant_ext;
    logic [R-1:0]                    w_grant_rec;
    logic [R-1:0][RR_W-1:0]          w_rec_k;
    logic [R-1:0][ADDR_WIDTH-1:0]    w_rec_addr;
    logic [R-1:0][RR_W-1:0]          w_rr_next;

    // Per-column grant / drop
    logic [NUM_COLS-1:0]             w_col_grant;
    logic [NUM_COLS-1:0]             w_drop;
    logic [CNT_W-1:0]                w_drop_n;
    logic [SUM_W-1:0]                w_drop_sum;
    logic [DROP_CNT_WIDTH-1:0]       w_drop_next;

    genvar gr, gk, gc;

    generate
        for (gr = 0; gr < R; gr++) begin : g_row
            // Row gr owns columns gr, gr+R, gr+2R, ...; local index k maps to column gr+k*R.
            localparam int K_R   = (gr < NUM_COLS) ? ((NUM_COLS - gr + R - 1) / R) : 0;
            localparam int K_MOD = (K_R > 0) ? K_R : 1;

            logic [K_MAX-1:0]       w_row_pend;
            logic                   w_found;
            logic [RR_W-1:0]        w_k;
            logic [ADDR_WIDTH-1:0]  w_addr;
            logic [RR_W-1:0]        w_rr_nxt;

            for (gk = 0; gk < K_MAX; gk++) begin : g_k
                if (gr + gk * R < NUM_COLS) begin : g_in
                    assign w_row_pend[gk] = r_pend[gr + gk * R];
                end else begin : g_out
                    assign w_row_pend[gk] = 1'b0;
                end
            end

            // Round-robin pick: first pending column at or after the start pointer.
            always_comb begin
                w_found  = 1'b0;
                w_k      = '0;
                w_addr   = '0;
                w_rr_nxt = r_rr[gr];
                for (int i = 0; i < K_MAX; i++) begin
                    for (int k = 0; k < K_MAX; k++) begin
                        if (!w_found && (i < K_R) && (k < K_R) && w_row_pend[k] &&
                            (k == ((int'(r_rr[gr]) + i) % K_MOD))) begin
                            w_found  = 1'b1;
                            w_k      = RR_W'(k);
                            w_addr   = ADDR_WIDTH'(REC_ADDR_BASE + gr + k * R);
                            w_rr_nxt = RR_W'((k + 1) % K_MOD);
                        end
                    end
                end
            end

            assign w_rec_avail[gr] = w_found;
            assign w_rec_k[gr]     = w_k;
            assign w_rec_addr[gr]  = w_addr;
            assign w_rr_next[gr]   = w_rr_nxt;
            // Under contention prio selects the side: 0 = external, 1 = recurrent.
            assign w_grant_ext[gr] = bus.ext_valid[gr] && (!w_found || !r_prio[gr]);
            assign w_grant_rec[gr] = w_found && (!bus.ext_valid[gr] || r_prio[gr]);
        end

        for (gc = 0; gc < NUM_COLS; gc++) begin : g_col
            assign w_col_grant[gc] = w_grant_rec[gc % R] &&
                                     (w_rec_k[gc % R] == RR_W'(gc / R));
            // A spike on an already-pending column that is not drained this cycle is lost.
            assign w_drop[gc]      = nrn_spike[gc] && r_pend[gc] && !w_col_grant[gc];
        end
    endgenerate

    // Saturating add of all drops seen this cycle.
    always_comb begin
        w_drop_n = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            w_drop_n = w_drop_n + CNT_W'(w_drop[c]);
        end
        w_drop_sum = SUM_W'(r_drop_cnt) + SUM_W'(w_drop_n);
        if (w_drop_sum > SUM_W'({DROP_CNT_WIDTH{1'b1}})) begin
            w_drop_next = '1;
        end else begin
            w_drop_next = w_drop_sum[DROP_CNT_WIDTH-1:0];
        end
    end

    // Pending flags, arbitration state, output registers and drop counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend      <= '0;
            r_rr        <= '0;
            r_prio      <= '0;
            r_out_valid <= '0;
            r_out_addr  <= '0;
            r_out_rec   <= '0;
            r_drop_cnt  <= '0;
        end else begin
            // A new spike re-arms the flag even when the column is granted this cycle.
            r_pend     <= nrn_spike | (r_pend & ~w_col_grant);
            r_drop_cnt <= drop_clr ? '0 : w_drop_next;
            for (int r = 0; r < R; r++) begin
                if (w_grant_ext[r] || w_grant_rec[r]) begin
                    r_out_valid[r] <= 1'b1;
                    r_out_addr[r]  <= w_grant_rec[r] ? w_rec_addr[r] : bus.ext_addr[r];
                    r_out_rec[r]   <= w_grant_rec[r];
                end else begin
                    r_out_valid[r] <= 1'b0;
                end
                if (w_grant_rec[r]) begin
                    r_rr[r] <= w_rr_next[r];
                end
                if (bus.ext_valid[r] && w_rec_avail[r]) begin
                    r_prio[r] <= ~r_prio[r];
                end
            end
        end
    end

    assign bus.ext_ready = w_grant_ext & {R{reset_n}};
    assign bus.out_valid = r_out_valid;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_rec   = r_out_rec;
    assign drop_cnt      = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_spike_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_row_scheduler
// Description : Self-checking bench for spike_row_scheduler with directed
//               scenarios and randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_row_scheduler;
    localparam int R    = 2;
    localparam int C    = 4;
    localparam int AW   = 6;
    localparam int BASE = 32;
    localparam int DW   = 2;
    localparam int DMAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [C-1:0]  nrn_spike = '0;
    logic          drop_clr = 1'b0;
    logic [DW-1:0] drop_cnt;

    spike_row_scheduler_if #(.NUM_SYNAPSE_ROWS(R), .ADDR_WIDTH(AW)) bus ();

    spike_row_scheduler #(
        .NUM_SYNAPSE_ROWS(R), .NUM_COLS(C), .ADDR_WIDTH(AW),
        .REC_ADDR_BASE(BASE), .DROP_CNT_WIDTH(DW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave),
        .nrn_spike(nrn_spike), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit m_pend[C];
    int m_rr[R];      // local index of the row's column where the next search starts
    bit m_prio[R];
    bit m_ov[R];
    int m_oa[R];
    bit m_orec[R];
    int m_drop;
    bit m_acc[R];
    bit last_ready[R];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < C; c++) m_pend[c] = 0;
        for (int r = 0; r < R; r++) begin
            m_rr[r] = 0; m_prio[r] = 0; m_ov[r] = 0; m_oa[r] = 0; m_orec[r] = 0; m_acc[r] = 0;
        end
        m_drop = 0;
    endtask

    // One clock cycle: inputs are already driven (called just after a negedge).
    task automatic step();
        int cols[$];
        bit granted[C];
        int drops, pick, cpick, k;
        bit ev, gext, grec;
        #1;
        for (int c = 0; c < C; c++) granted[c] = 0;
        for (int r = 0; r < R; r++) begin
            cols.delete();
            for (int c = 0; c < C; c++) if (c % R == r) cols.push_back(c);
            pick = -1;
            for (int i = 0; i < cols.size(); i++) begin
                k = (m_rr[r] + i) % cols.size();
                if (pick < 0 && m_pend[cols[k]]) pick = k;
            end
            ev   = bus.ext_valid[r];
            gext = ev && (pick < 0 || !m_prio[r]);
            grec = (pick >= 0) && (!ev || m_prio[r]);
            last_ready[r] = bus.ext_ready[r];
            check_val($sformatf("ext_ready[%0d]", r), bus.ext_ready[r], gext);
            if (ev && pick >= 0) m_prio[r] = !m_prio[r];
            m_acc[r] = gext;
            m_ov[r]  = gext || grec;
            if (gext) begin
                m_oa[r] = bus.ext_addr[r]; m_orec[r] = 0;
            end else if (grec) begin
                cpick = cols[pick];
                granted[cpick] = 1;
                m_oa[r]   = (BASE + cpick) % (1 << AW);
                m_orec[r] = 1;
                m_rr[r]   = (pick + 1) % cols.size();
            end
        end
        drops = 0;
        for (int c = 0; c < C; c++) begin
            if (nrn_spike[c] && m_pend[c] && !granted[c]) drops++;
            m_pend[c] = nrn_spike[c] || (m_pend[c] && !granted[c]);
        end
        if (drop_clr) m_drop = 0;
        else          m_drop = (m_drop + drops > DMAX) ? DMAX : m_drop + drops;
        @(posedge clk);
        #1;
        for (int r = 0; r < R; r++) begin
            check_val($sformatf("out_valid[%0d]", r), bus.out_valid[r], m_ov[r]);
            check_val($sformatf("out_addr[%0d]", r),  bus.out_addr[r],  m_oa[r]);
            check_val($sformatf("out_rec[%0d]", r),   bus.out_rec[r],   m_orec[r]);
        end
        check_val("drop_cnt", drop_cnt, m_drop);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges, released at a negedge.
    task automatic do_reset();
        nrn_spike = '0;
        drop_clr  = 1'b0;
        bus.ext_valid = '1;
        #2 reset_n = 1'b0;
        #1;
        for (int r = 0; r < R; r++) begin
            check_val($sformatf("rst_out_valid[%0d]", r), bus.out_valid[r], 0);
            check_val($sformatf("rst_out_addr[%0d]", r),  bus.out_addr[r],  0);
            check_val($sformatf("rst_out_rec[%0d]", r),   bus.out_rec[r],   0);
            check_val($sformatf("rst_ext_ready[%0d]", r), bus.ext_ready[r], 0);
        end
        check_val("rst_drop_cnt", drop_cnt, 0);
        model_reset();
        bus.ext_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < R; r++) begin
                if (!bus.ext_valid[r] || m_acc[r]) begin
                    bus.ext_valid[r] = ($urandom_range(0, 99) < 55);
                    bus.ext_addr[r]  = AW'($urandom_range(0, (1 << AW) - 1));
                end
            end
            for (int c = 0; c < C; c++) nrn_spike[c] = ($urandom_range(0, 99) < 40);
            drop_clr = ($urandom_range(0, 19) == 0);
            step();
        end
        nrn_spike = '0;
        drop_clr  = 1'b0;
        bus.ext_valid = '0;
        for (int r = 0; r < R; r++) m_acc[r] = 0;
    endtask

    initial begin
        int xfers;
        bit done;
        bus.ext_valid = '0;
        bus.ext_addr  = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        random_run(200);

        // Reset mid-run with pending spikes, then an external spike on row 1.
        nrn_spike = '1;
        bus.ext_valid = 2'b11;
        step();
        do_reset();
        bus.ext_valid = 2'b10;
        bus.ext_addr[1] = AW'(5);
        step();
        check_val("ext5_valid", bus.out_valid[1], 1);
        check_val("ext5_addr",  bus.out_addr[1],  5);
        check_val("ext5_rec",   bus.out_rec[1],   0);
        check_val("ext5_row0_idle", bus.out_valid[0], 0);
        bus.ext_valid = '0;

        // Contention fairness on row 0: ext, rec, ext, rec.
        nrn_spike = 4'b0001;
        step();
        check_val("cont_idle", bus.out_valid[0], 0);
        nrn_spike = '0;
        bus.ext_valid = 2'b01;
        bus.ext_addr[0] = AW'(3);
        step();
        check_val("cont1_rec", bus.out_rec[0], 0);
        check_val("cont1_addr", bus.out_addr[0], 3);
        nrn_spike = 4'b0001;
        step();
        check_val("cont2_rec", bus.out_rec[0], 1);
        check_val("cont2_addr", bus.out_addr[0], 32);
        nrn_spike = '0;
        step();
        check_val("cont3_rec", bus.out_rec[0], 0);
        step();
        check_val("cont4_rec", bus.out_rec[0], 1);
        check_val("cont_no_drop", drop_cnt, 0);
        bus.ext_valid = '0;

        // Recurrent path: two-cycle latency from the spike pulse.
        nrn_spike = 4'b0010;
        step();
        check_val("rec_early", bus.out_valid[1], 0);
        nrn_spike = '0;
        step();
        check_val("rec_valid", bus.out_valid[1], 1);
        check_val("rec_addr",  bus.out_addr[1],  33);
        check_val("rec_flag",  bus.out_rec[1],   1);
        check_val("rec_row0",  bus.out_valid[0], 0);

        // Round-robin across row 0's two columns.
        do_reset();
        nrn_spike = 4'b0101;
        step();
        nrn_spike = '0;
        step();
        check_val("rr_first", bus.out_addr[0], 32);
        step();
        check_val("rr_second", bus.out_addr[0], 34);
        check_val("rr_valid", bus.out_valid[0], 1);
        check_val("rr_no_drop", drop_cnt, 0);

        // Drop saturation, then clear against a simultaneous drop.
        bus.ext_valid = 2'b01;
        bus.ext_addr[0] = AW'(3);
        nrn_spike = 4'b0001;
        for (int i = 0; i < 8; i++) step();
        check_val("drop_sat", drop_cnt, 3);
        bus.ext_valid = '0;
        nrn_spike = '1;
        step();
        drop_clr = 1'b1;
        step();
        check_val("drop_clr", drop_cnt, 0);
        drop_clr = 1'b0;
        nrn_spike = '0;
        step();
        step();

        // Handshake stability under recurrent contention.
        do_reset();
        nrn_spike = 4'b0101;
        step();
        nrn_spike = '0;
        bus.ext_valid = 2'b01;
        bus.ext_addr[0] = AW'(11);
        step();
        bus.ext_addr[0] = AW'(9);
        xfers = 0;
        done  = 0;
        for (int i = 0; i < 6 && !done; i++) begin
            step();
            if (last_ready[0]) begin
                xfers++;
                done = 1;
                check_val("hs_addr", bus.out_addr[0], 9);
                check_val("hs_rec",  bus.out_rec[0],  0);
            end
        end
        check_val("hs_xfers", xfers, 1);
        bus.ext_valid = '0;
        for (int r = 0; r < R; r++) m_acc[r] = 0;

        random_run(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
